// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the digit-serial adder/subtractor.
//   state_t    : control states IDLE / RUN / DONE
//   cnt_width  : width of the digit counter, clog2(ndig) but never below 1
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit configuration still needs a 1-bit counter to be legal.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Purely combinational DIGIT-bit ripple adder slice.
// Ports:
//   a_d, b_d  : DIGIT-bit operand digits
//   cin       : carry into bit 0
//   s_d       : DIGIT-bit sum digit
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (used for signed overflow)
// -----------------------------------------------------------------------------
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] carry_s;

    // Bit-level ripple chain; carry_s[i] is the carry into bit i.
    always_comb begin
        carry_s    = '0;
        s_d        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s_d[i]       = a_d[i] ^ b_d[i] ^ carry_s[i];
            carry_s[i+1] = (a_d[i] & b_d[i]) | (carry_s[i] & (a_d[i] ^ b_d[i]));
        end
    end

    assign cout     = carry_s[DIGIT];
    assign c_msb_in = carry_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Digit-serial adder/subtractor: adds two WIDTH-bit operands DIGIT bits per
// cycle, LSB digit first, using one digit_adder slice and a registered carry.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output
// (two's-complement signed overflow of the selected operation).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, c_in, sub      : operands, carry-in (add only), 1 = subtract a-b
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   sum, c_out           : result and carry out of MSB (sub: 1 = no borrow)
//   ovf                  : signed overflow (only with SERIAL_ADDER_OVF_EN)
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_adder: WIDTH (%0d) must be >= 1 and a multiple of DIGIT (%0d)",
                   WIDTH, DIGIT);
        end
    endgenerate

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  sum_r;
    logic              c_out_r;
    logic              ovf_r;

    logic [DIGIT-1:0]  slice_sum_s;
    logic              slice_cout_s;
    logic              slice_cmsb_s;
    logic [WIDTH-1:0]  sum_next_s;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_d      (a_r[DIGIT-1:0]),
        .b_d      (b_r[DIGIT-1:0]),
        .cin      (carry_r),
        .s_d      (slice_sum_s),
        .cout     (slice_cout_s),
        .c_msb_in (slice_cmsb_s)
    );

    // New digit enters at the MSB end; after NDIG shifts the LSB digit sits at bit 0.
    // Written with shifts so that DIGIT == WIDTH needs no special-case slicing.
    assign sum_next_s = (sum_r >> DIGIT) | (WIDTH'(slice_sum_s) << (WIDTH - DIGIT));

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b once here, seed carry with 1.
                        a_r     <= a;
                        b_r     <= b ^ {WIDTH{sub}};
                        carry_r <= sub ? 1'b1 : c_in;
                        cnt_r   <= '0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= slice_cout_s;
                    sum_r   <= sum_next_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (cnt_r == LAST_DIG) begin
                        c_out_r <= slice_cout_s;
                        // On the last digit the slice's top bit is the operand MSB.
                        ovf_r   <= slice_cmsb_s ^ slice_cout_s;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign sum       = sum_r;
    assign c_out     = c_out_r;

`ifdef SERIAL_ADDER_OVF_EN
    assign ovf = ovf_r;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Scoreboard bench for serial_adder: the driver pushes expected results from
// a plain-arithmetic reference model, a monitor pops and compares on each
// result handshake. Also covers backpressure, mid-run reset and the 8/1, 8/8
// parameter points.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int ND = W / D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    // 8-bit sweep instances share inputs
    logic         s8_iv;
    logic [7:0]   s8_a;
    logic [7:0]   s8_b;
    logic         s8_cin;
    logic         s8_sub;
    logic         r1_ready, r1_valid, r1_cout;
    logic [7:0]   r1_sum;
    logic         r2_ready, r2_valid, r2_cout;
    logic [7:0]   r2_sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         r1_ovf, r2_ovf;
`endif

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut_8x1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s8_iv), .in_ready(r1_ready),
        .a(s8_a), .b(s8_b), .c_in(s8_cin), .sub(s8_sub), .out_valid(r1_valid),
        .out_ready(1'b1), .sum(r1_sum), .c_out(r1_cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(r1_ovf)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut_8x8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s8_iv), .in_ready(r2_ready),
        .a(s8_a), .b(s8_b), .c_in(s8_cin), .sub(s8_sub), .out_valid(r2_valid),
        .out_ready(1'b1), .sum(r2_sum), .c_out(r2_cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(r2_ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    logic rnd_bp     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb    = ms ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
        e.s   = full[W-1:0];
        e.c   = full[W];
        // Signed overflow: operands of equal sign give a result of the other sign.
        e.v   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        e.acc = 0;
        return e;
    endfunction

    // Monitor: latency on each rising out_valid, result compare on each handshake.
    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    check("result_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0)
                        check("latency", 64'(cyc - exp_q[0].acc), 64'(ND));
                end
                if (out_valid && out_ready && (exp_q.size() != 0)) begin
                    e = exp_q.pop_front();
                    check("sum", 64'(sum), 64'(e.s));
                    check("c_out", 64'(c_out), 64'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf", 64'(ovf), 64'(e.v));
`endif
                end
                prev_valid = out_valid;
            end
        end
    end

    // Random backpressure on the result side while rnd_bp is set.
    initial begin : bp_driver
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
        int   n;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1; a = ta; b = tb; c_in = tc; sub = ts;
        n = 0;
        @(negedge clk);
        while (!in_ready && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(0), 64'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e     = model(ta, tb, tc, ts);
        e.acc = cyc;
        exp_q.push_back(e);
        // Scramble inputs after the accept; they must have no effect.
        in_valid = 1'b0; a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (((exp_q.size() != 0) || !in_ready) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic sweep(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic ts);
        logic [8:0] full;
        logic [7:0] bb;
        int         acc, lat1, lat2;
        logic [7:0] s1, s2;
        logic       c1, c2;
        bb   = ts ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, bb} + {8'd0, (ts ? 1'b1 : tc)};
        @(posedge clk);
        #1;
        s8_iv = 1'b1; s8_a = ta; s8_b = tb; s8_cin = tc; s8_sub = ts;
        @(negedge clk);
        check("sweep_in_ready", 64'({r1_ready, r2_ready}), 64'(2'b11));
        @(posedge clk);
        #1;
        acc = cyc; s8_iv = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom);
        lat1 = -1; lat2 = -1; s1 = 8'd0; s2 = 8'd0; c1 = 1'b0; c2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r1_valid && (lat1 < 0)) begin lat1 = cyc - acc; s1 = r1_sum; c1 = r1_cout; end
            if (r2_valid && (lat2 < 0)) begin lat2 = cyc - acc; s2 = r2_sum; c2 = r2_cout; end
        end
        check("lat_8x1", 64'(lat1), 64'(8));
        check("lat_8x8", 64'(lat2), 64'(1));
        check("sum_8x1", 64'(s1), 64'(full[7:0]));
        check("sum_8x8", 64'(s2), 64'(full[7:0]));
        check("cout_8x1", 64'(c1), 64'(full[8]));
        check("cout_8x8", 64'(c2), 64'(full[8]));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W-1:0] held_s;
        logic         held_c;
        logic [W-1:0] corner [5];
        exp_t         e;
        int           n;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        s8_iv = 1'b0; s8_a = 8'd0; s8_b = 8'd0; s8_cin = 1'b0; s8_sub = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_c_out", 64'(c_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);   // c_in ignored on sub
        wait_idle();

        // Backpressure in DONE with a competing request
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", 64'(out_valid), 64'(1));
        held_s = sum; held_c = c_out;
        @(posedge clk);
        #1;
        in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0101_0101; c_in = 1'b0; sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum_stable", 64'(sum), 64'(held_s));
            check("bp_cout_stable", 64'(c_out), 64'(held_c));
            check("bp_in_ready_low", 64'(in_ready), 64'(0));
            check("bp_out_valid_high", 64'(out_valid), 64'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);                      // handshake pending; monitor pops here
        @(negedge clk);
        check("bp_in_ready_after", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        e     = model(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
        e.acc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        wait_idle();

        // Reset three cycles into RUN
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_sum", 64'(sum), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_idle();

        // Randomized operations with random result backpressure
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h0000_0001;
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            send(ra, rb, 1'($urandom), 1'($urandom));
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_idle();

        // Parameter sweep: 8/1 and 8/8
        sweep(8'hAA, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sweep(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
